tick_divider_multi: RTL and testbench
=====================================

// Module: tick_divider_multi
// PURPOSE
//  Parametrised multi-channel tick generator. Each channel divides qualified input
//  cycles by a run-time divisor and emits a 1-cycle tick plus a 50%-duty level.
//  Channels run independently or as a cascade (e.g. 1ms->10ms->100ms->1s) and feed
//  game timers, debouncers and display refresh from a single clock domain.
// PARAMETERS
//  NUM_CH       4    number of divider channels (>=1)
//  WIDTH        16   counter/divisor width in bits
//  DEFAULT_DIV  10   divisor loaded into every channel at reset (must fit WIDTH)
//  CASCADE      1    1: channel i>0 is qualified by tick[i-1]; 0: all channels use ce
// PORTS
//  clk      in   1               system clock, rising edge
//  reset_n  in   1               asynchronous active-low reset
//  clr      in   1               synchronous clear of all channels
//  ce       in   1               count enable / input tick for channel 0 (all if CASCADE=0)
//  ch_en    in   NUM_CH          per-channel enable
//  div_in   in   NUM_CH*WIDTH    divisor values; channel i = div_in[i*WIDTH +: WIDTH]
//  div_ld   in   NUM_CH          per-channel divisor load strobe (1 cycle)
//  tick     out  NUM_CH          registered 1-cycle pulse per completed period
//  level    out  NUM_CH          registered square wave, toggles at each period end
// BEHAVIOUR
//  Per channel: cnt[WIDTH], div_act[WIDTH], div_pend[WIDTH], pend_v, tick, level regs.
//  Reset (reset_n=0, async, no clock needed): cnt=0, div_act=DEFAULT_DIV, pend_v=0,
//   tick=0, level=0 on all channels.
//  Qualifier q[i]: CASCADE=0 -> ce; CASCADE=1 -> i==0 ? ce : tick[i-1] (registered).
//  Priority per edge: clr > !ch_en[i] > counting.
//  clr or !ch_en[i]: cnt<=0, tick<=0, level<=0; if pend_v apply div_pend (pend_v<=0).
//  Counting (ch_en[i]=1, div_act!=0, q[i]=1):
//   cnt==div_act-1 -> cnt<=0, tick<=1, level<=~level, apply div_pend if pend_v.
//   else           -> cnt<=cnt+1, tick<=0.
//  q[i]=0 or div_act==0: cnt holds, tick<=0, level holds. div_act=0 = channel parked.
//  Tick timing: with q held 1 and div D from cnt=0, tick is high during the cycle
//   after the D-th qualified edge; period exactly D qualified cycles (D=1: tick
//   every cycle). level period = 2*D qualified cycles.
//  Cascade latency: +1 clk per stage; stage i ticks once per prod(div[0..i]) cycles.
//  Divisor load: div_ld[i] captures slice into div_pend, pend_v<=1. Never changes
//   div_act mid-period; applied only at wrap, clr or disable. Back-to-back loads:
//   last wins. Load coincident with wrap: new value applied at that same edge.
//  Load coincident with clr/disable: new value applied at that edge.
//  cnt never exceeds div_act-1; all arithmetic is WIDTH bits, unsigned, no overflow.
//  reset_n deasserted mid-operation: restart from reset state; first tick after
//   DEFAULT_DIV qualified cycles.
// TESTING
//  1 CASCADE=0,NUM_CH=1,div=10,ce=1,ch_en=1 -> tick high cycles 10,20,30 after
//    reset release; level toggles at each, period 20.
//  2 CASCADE=1,NUM_CH=2,div 10/10,ce=1 -> tick[1] once per 100 cycles, exactly 1
//    cycle after every 10th tick[0].
//  3 div=10, div_ld with 3 when cnt=4 -> current period still ends at 10, next
//    periods are 3; two loads (5 then 7) in one period -> 7 used.
//  4 ce toggling 1,0,1,0, div=4 -> tick every 8 clocks; div_ld 0 -> after wrap no
//    further ticks, cnt stays 0, level frozen.
//  5 clr at cnt=6 -> next edge cnt=0,tick=0,level=0, next tick 10 cycles later;
//    ch_en low 3 cycles -> same clear behaviour.
//  6 reset_n pulsed low between clock edges mid-count -> tick/level/cnt clear
//    immediately; div_act returns to DEFAULT_DIV even after a prior load.

Source files
------------

// File: rtl/tick_divider_multi.sv
// rtl/tick_divider_multi.sv - multi-channel tick divider with optional cascade
// Each channel divides qualified cycles by a run-time divisor and emits a tick and a 50% level.
module tick_divider_multi #(
  parameter int NUM_CH      = 4,
  parameter int WIDTH       = 16,
  parameter int DEFAULT_DIV = 10,
  parameter int CASCADE     = 1
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    clr,
  input  logic                    ce,
  input  logic [NUM_CH-1:0]       ch_en,
  input  logic [NUM_CH*WIDTH-1:0] div_in,
  input  logic [NUM_CH-1:0]       div_ld,
  output logic [NUM_CH-1:0]       tick,
  output logic [NUM_CH-1:0]       level
);

  localparam logic [WIDTH-1:0] DEF_DIV = WIDTH'(DEFAULT_DIV);
  localparam logic [WIDTH-1:0] ONE     = WIDTH'(1);

  logic [NUM_CH-1:0] qual;

  for (genvar i = 0; i < NUM_CH; i++) begin : g_ch
    logic [WIDTH-1:0] cnt_q, cnt_d;
    logic [WIDTH-1:0] div_act_q, div_act_d;
    logic [WIDTH-1:0] div_pend_q, div_pend_d;
    logic             pend_v_q, pend_v_d;
    logic             tick_q, tick_d;
    logic             level_q, level_d;
    logic [WIDTH-1:0] div_new;
    logic [WIDTH-1:0] next_div;
    logic             has_next;

    // Cascaded stages count the registered tick of the previous stage.
    if (CASCADE != 0 && i > 0) begin : g_casc
      assign qual[i] = g_ch[i-1].tick_q;
    end else begin : g_ce
      assign qual[i] = ce;
    end

    assign div_new  = div_in[i*WIDTH +: WIDTH];
    // A load in the same cycle as an apply point takes effect at that edge.
    assign has_next = div_ld[i] | pend_v_q;
    assign next_div = div_ld[i] ? div_new : div_pend_q;

    always_comb begin
      cnt_d      = cnt_q;
      div_act_d  = div_act_q;
      div_pend_d = div_ld[i] ? div_new : div_pend_q;
      pend_v_d   = pend_v_q | div_ld[i];
      tick_d     = 1'b0;
      level_d    = level_q;
      if (clr || !ch_en[i]) begin
        cnt_d   = '0;
        level_d = 1'b0;
        if (has_next) begin
          div_act_d = next_div;
          pend_v_d  = 1'b0;
        end
      end else if (div_act_q != '0 && qual[i]) begin
        if (cnt_q == div_act_q - ONE) begin
          cnt_d   = '0;
          tick_d  = 1'b1;
          level_d = ~level_q;
          if (has_next) begin
            div_act_d = next_div;
            pend_v_d  = 1'b0;
          end
        end else begin
          cnt_d = cnt_q + ONE;
        end
      end
    end

    always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
        cnt_q      <= '0;
        div_act_q  <= DEF_DIV;
        div_pend_q <= '0;
        pend_v_q   <= 1'b0;
        tick_q     <= 1'b0;
        level_q    <= 1'b0;
      end else begin
        cnt_q      <= cnt_d;
        div_act_q  <= div_act_d;
        div_pend_q <= div_pend_d;
        pend_v_q   <= pend_v_d;
        tick_q     <= tick_d;
        level_q    <= level_d;
      end
    end

    assign tick[i]  = tick_q;
    assign level[i] = level_q;
  end

endmodule

// File: tb/tb_tick_divider_multi.sv
// tb/tb_tick_divider_multi.sv - directed and randomized check of tick_divider_multi
module tb_tick_divider_multi;
  localparam int NUM_CH = 3;
  localparam int WIDTH  = 16;
  localparam int DEFDIV = 10;

  logic                    clk = 1'b0;
  logic                    reset_n;
  logic                    clr;
  logic                    ce;
  logic [NUM_CH-1:0]       ch_en;
  logic [NUM_CH*WIDTH-1:0] div_in;
  logic [NUM_CH-1:0]       div_ld;
  logic [NUM_CH-1:0]       tick;
  logic [NUM_CH-1:0]       level;

  int n_checks = 0;
  int n_fail   = 0;

  int m_cnt [NUM_CH];
  int m_div [NUM_CH];
  int m_pend[NUM_CH];
  bit m_pv  [NUM_CH];
  bit m_tick[NUM_CH];
  bit m_lvl [NUM_CH];

  tick_divider_multi #(
    .NUM_CH(NUM_CH), .WIDTH(WIDTH), .DEFAULT_DIV(DEFDIV), .CASCADE(1)
  ) dut (
    .clk(clk), .reset_n(reset_n), .clr(clr), .ce(ce), .ch_en(ch_en),
    .div_in(div_in), .div_ld(div_ld), .tick(tick), .level(level)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < NUM_CH; i++) begin
      m_cnt[i] = 0; m_div[i] = DEFDIV; m_pend[i] = 0;
      m_pv[i] = 0; m_tick[i] = 0; m_lvl[i] = 0;
    end
  endtask

  // One rising edge of the reference: a period of m_div qualified cycles.
  task automatic model_step();
    bit old_tick[NUM_CH];
    bit q;
    int nv;
    for (int i = 0; i < NUM_CH; i++) old_tick[i] = m_tick[i];
    for (int i = 0; i < NUM_CH; i++) begin
      q  = (i == 0) ? ce : old_tick[i-1];
      nv = int'(div_in[i*WIDTH +: WIDTH]);
      m_tick[i] = 0;
      if (clr || !ch_en[i]) begin
        m_cnt[i] = 0; m_lvl[i] = 0;
        if (div_ld[i]) begin m_div[i] = nv; m_pv[i] = 0; end
        else if (m_pv[i]) begin m_div[i] = m_pend[i]; m_pv[i] = 0; end
      end else if (m_div[i] != 0 && q && m_cnt[i] + 1 == m_div[i]) begin
        m_cnt[i] = 0; m_tick[i] = 1; m_lvl[i] = !m_lvl[i];
        if (div_ld[i]) begin m_div[i] = nv; m_pv[i] = 0; end
        else if (m_pv[i]) begin m_div[i] = m_pend[i]; m_pv[i] = 0; end
      end else begin
        if (m_div[i] != 0 && q) m_cnt[i]++;
        if (div_ld[i]) begin m_pend[i] = nv; m_pv[i] = 1; end
      end
    end
  endtask

  task automatic step();
    model_step();
    @(negedge clk);
    for (int i = 0; i < NUM_CH; i++) begin
      check($sformatf("tick%0d", i), 32'(tick[i]), 32'(m_tick[i]));
      check($sformatf("level%0d", i), 32'(level[i]), 32'(m_lvl[i]));
    end
  endtask

  task automatic set_div(input int ch, input int v);
    div_in[ch*WIDTH +: WIDTH] = WIDTH'(v);
  endtask

  initial begin
    reset_n = 1'b0; clr = 1'b0; ce = 1'b0; ch_en = '0; div_in = '0; div_ld = '0;
    model_reset();
    #1;
    check("reset_tick", 32'(tick), 32'd0);
    check("reset_level", 32'(level), 32'd0);
    @(negedge clk); @(negedge clk);

    // Single channel, divisor 10: ticks at edges 10, 20, 30.
    reset_n = 1'b1; ce = 1'b1; ch_en = 3'b001;
    for (int k = 1; k <= 30; k++) begin
      step();
      check("t1_tick", 32'(tick[0]), 32'(k % 10 == 0));
      check("t1_level", 32'(level[0]), 32'((k / 10) % 2));
    end

    // Cascade 10/10: tick[1] one cycle after every 10th tick[0].
    clr = 1'b1; step(); clr = 1'b0;
    ch_en = 3'b011;
    for (int k = 1; k <= 210; k++) begin
      step();
      check("t2_tick1", 32'(tick[1]), 32'(k >= 101 && k % 100 == 1));
    end

    // Divisor load mid-period, then two loads in one period.
    ch_en = 3'b001; clr = 1'b1; step(); clr = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      div_ld = '0;
      if (k == 5)  begin set_div(0, 3); div_ld = 3'b001; end
      if (k == 20) begin set_div(0, 5); div_ld = 3'b001; end
      if (k == 21) begin set_div(0, 7); div_ld = 3'b001; end
      step();
      check("t3_tick", 32'(tick[0]),
            32'(k == 10 || k == 13 || k == 16 || k == 19 || k == 22 || k == 29 || k == 36));
    end
    div_ld = '0;

    // ce toggling with divisor 4 (load coincident with clr), then park with 0.
    set_div(0, 4); div_ld = 3'b001; clr = 1'b1; step(); clr = 1'b0; div_ld = '0;
    for (int k = 1; k <= 70; k++) begin
      ce = k[0];
      div_ld = '0;
      if (k == 33) begin set_div(0, 0); div_ld = 3'b001; end
      step();
      check("t4_tick", 32'(tick[0]), 32'((k <= 39) && (k % 8 == 7)));
    end
    div_ld = '0; ce = 1'b1;

    // Clear at cnt=6, then disable for 3 cycles.
    set_div(0, 10); div_ld = 3'b001; clr = 1'b1; step(); clr = 1'b0; div_ld = '0;
    for (int k = 1; k <= 6; k++) step();
    clr = 1'b1; step(); clr = 1'b0;
    check("t5_clr_level", 32'(level[0]), 32'd0);
    for (int k = 1; k <= 10; k++) begin
      step();
      check("t5_after_clr", 32'(tick[0]), 32'(k == 10));
    end
    for (int k = 1; k <= 4; k++) step();
    ch_en = 3'b000; for (int k = 0; k < 3; k++) step();
    ch_en = 3'b001; for (int k = 0; k < 12; k++) step();

    // Async reset mid-count after loading divisor 3.
    set_div(0, 3); div_ld = 3'b001; clr = 1'b1; step(); clr = 1'b0; div_ld = '0;
    for (int k = 0; k < 4; k++) step();
    #2 reset_n = 1'b0;
    #1;
    check("t6_async_tick", 32'(tick), 32'd0);
    check("t6_async_level", 32'(level), 32'd0);
    model_reset();
    @(negedge clk); reset_n = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      step();
      check("t6_default_div", 32'(tick[0]), 32'(k % 10 == 0));
    end

    // Randomized traffic against the reference.
    ch_en = 3'b111;
    for (int n = 0; n < 1500; n++) begin
      ce = ($urandom % 4) != 0;
      clr = ($urandom % 64) == 0;
      for (int i = 0; i < NUM_CH; i++) begin
        ch_en[i] = ($urandom % 16) != 0;
        div_ld[i] = ($urandom % 16) == 0;
        set_div(i, int'($urandom % 6));
      end
      step();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule
